// File: rtl/truth_table_sweeper_if.sv
// Host/gate-side bundle for truth_table_sweeper: sweep control, gate drive/sense
// and the result registers of the last completed sweep.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [2:0] gate_in;
  logic       gate_out;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       pass;
  logic [7:0] mismatch;
  logic [7:0] unstable;

  modport master (
    output start, abort, gate_out,
    input  gate_in, busy, done, table_out, pass, mismatch, unstable
  );

  modport slave (
    input  start, abort, gate_out,
    output gate_in, busy, done, table_out, pass, mismatch, unstable
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through its 8 rows, samples each row after a settle time and
// grades the measured truth table. Define SWEEP_VOTE_EN for 3-sample majority voting per row.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [7:0]  EXPECTED      = 8'hDD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);

  localparam int                CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES must be >= 1");
  end

  logic [1:0]       state;
  logic [2:0]       row;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       work_tbl;
  logic [7:0]       tbl_next;
  logic [7:0]       table_r;
  logic [7:0]       mismatch_r;
  logic             pass_r;
  logic             bit_now;
  logic             launch;
  logic             capture;
  logic             finish;

  // A sweep may start from IDLE or straight out of the DONE cycle; abort always wins.
  assign launch  = bus.start && !bus.abort && ((state == IDLE) || (state == DONE));
  assign capture = (state == RUN) && (cnt == '0) && !bus.abort;
  assign finish  = capture && (row == 3'd7);

`ifdef SWEEP_VOTE_EN
  logic       smp_p0;
  logic       smp_p1;
  logic       uns_now;
  logic [7:0] work_uns;
  logic [7:0] uns_next;
  logic [7:0] unstable_r;

  if (SETTLE_CYCLES < 3) begin : g_bad_vote
    $error("truth_table_sweeper: SWEEP_VOTE_EN needs SETTLE_CYCLES >= 3");
  end

  // Samples from the third- and second-to-last edges of the row; the last edge is gate_out itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_p0 <= 1'b0;
      smp_p1 <= 1'b0;
    end else if (state == RUN) begin
      if (cnt == CNT_W'(2)) smp_p0 <= bus.gate_out;
      if (cnt == CNT_W'(1)) smp_p1 <= bus.gate_out;
    end
  end

  always_comb begin
    bit_now       = (smp_p0 & smp_p1) | (smp_p0 & bus.gate_out) | (smp_p1 & bus.gate_out);
    uns_now       = !((smp_p0 == smp_p1) && (smp_p1 == bus.gate_out));
    uns_next      = work_uns;
    uns_next[row] = uns_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_uns   <= '0;
      unstable_r <= '0;
    end else begin
      if (launch)       work_uns   <= '0;
      else if (capture) work_uns   <= uns_next;
      if (finish)       unstable_r <= uns_next;
    end
  end

  assign bus.unstable = unstable_r;
`else
  assign bit_now      = bus.gate_out;
  assign bus.unstable = '0;
`endif

  always_comb begin
    tbl_next      = work_tbl;
    tbl_next[row] = bit_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      cnt        <= RELOAD;
      work_tbl   <= '0;
      table_r    <= '0;
      pass_r     <= 1'b0;
      mismatch_r <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state    <= RUN;
            row      <= '0;
            cnt      <= RELOAD;
            work_tbl <= '0;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            work_tbl <= tbl_next;
            cnt      <= RELOAD;
            // Results are published on the row-7 edge so they are visible alongside done.
            if (row == 3'd7) begin
              state      <= DONE;
              table_r    <= tbl_next;
              pass_r     <= (tbl_next == EXPECTED);
              mismatch_r <= tbl_next ^ EXPECTED;
            end else begin
              row <= row + 3'd1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.gate_in   = (state == RUN) ? row : 3'd0;
  assign bus.table_out = table_r;
  assign bus.pass      = pass_r;
  assign bus.mismatch  = mismatch_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised scoreboard bench for truth_table_sweeper: a behavioural gate with optional
// single-cycle glitch, expected sweep results queued at start and checked when done pulses.
module tb_truth_table_sweeper;

`ifdef SWEEP_VOTE_EN
  localparam int S = 8;
`else
  localparam int S = 4;
`endif
  localparam logic [7:0] REF = 8'hDD;

  typedef struct {
    int unsigned done_edge;
    logic [7:0]  tbl;
    logic        pass;
    logic [7:0]  mis;
    logic [7:0]  uns;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  tt;
  int unsigned edge_n;
  int unsigned glitch_edge;
  int          total;
  int          bad;
  exp_t        q[$];
  exp_t        held;

  truth_table_sweeper_if bus ();

  truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(REF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural gate: truth table lookup, inverted for the one cycle feeding edge glitch_edge.
  assign bus.gate_out = tt[bus.gate_in] ^ ((edge_n + 1) == glitch_edge);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outcome of a sweep from the gate function and the single injected glitch
  // (row r, sample k edges before the row's last edge).
  function automatic exp_t model(input int unsigned de, input logic [7:0] f,
                                 input bit g, input int r, input int k);
    exp_t x;
    x.done_edge = de;
    x.tbl       = f;
    x.uns       = 8'h00;
`ifdef SWEEP_VOTE_EN
    if (g) x.uns[r] = 1'b1;
`else
    if (g && k == 0) x.tbl[r] = ~x.tbl[r];
`endif
    x.pass = (x.tbl == REF);
    x.mis  = x.tbl ^ REF;
    return x;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: pops on every done and checks result stability in every other cycle.
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      held = '{0, 8'h00, 1'b0, 8'h00, 8'h00};
    end else if (bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        x = q.pop_front();
        chk("done_edge", edge_n, x.done_edge);
        chk("table_out", bus.table_out, x.tbl);
        chk("pass", bus.pass, x.pass);
        chk("mismatch", bus.mismatch, x.mis);
        chk("unstable", bus.unstable, x.uns);
        chk("done_idle_drive", {bus.busy, bus.gate_in}, 0);
        held = x;
      end
    end else begin
      chk("results_hold", {bus.table_out, bus.pass, bus.mismatch, bus.unstable},
          {held.tbl, held.pass, held.mis, held.uns});
    end
  end

  task automatic run_sweep(input logic [7:0] f, input bit g, input int r, input int k,
                           input bit mid_start);
    int unsigned e0;
    tt          = f;
    e0          = edge_n + 1;
    glitch_edge = g ? e0 + (r + 1) * S - k : 0;
    q.push_back(model(e0 + 8 * S, f, g, r, k));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 8 * S; n++) begin
      chk("busy_run", bus.busy, 1);
      chk("gate_in_row", bus.gate_in, n / S);
      bus.start = (mid_start && n == 10);
      tick();
    end
    bus.start = 1'b0;
    tick();
    glitch_edge = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned e0;
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    tt          = REF;
    glitch_edge = 0;
    edge_n      = 0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {bus.gate_in, bus.busy, bus.done, bus.table_out, bus.pass,
                          bus.mismatch, bus.unstable}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_gate_in", {bus.busy, bus.gate_in}, 0);

    // Good gate, then stuck-at-0, then good again; the vote case glitches row 2's middle sample.
    run_sweep(REF, 0, 0, 0, 0);
    run_sweep(8'h00, 0, 0, 0, 0);
    run_sweep(REF, 0, 0, 0, 0);
    run_sweep(REF, 1, 2, 1, 0);
    run_sweep(REF, 1, 5, 0, 0);

    // Abort at row 4: no done, results untouched.
    tt = 8'h3C;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4 * S + 1) tick();
    chk("abort_row", bus.gate_in, 4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_idle", {bus.busy, bus.gate_in}, 0);
    repeat (3) tick();
    chk("abort_keep_table", {bus.table_out, bus.pass}, {held.tbl, held.pass});

    // Abort wins over a simultaneous start in IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_beats_start", bus.busy, 0);
    tick();

    // Start pulse mid-run is ignored.
    run_sweep(8'hA5, 0, 0, 0, 1);

    // Start held high: three back-to-back sweeps spaced 8*S+1 apart.
    tt = REF;
    e0 = edge_n + 1;
    for (int j = 0; j < 3; j++) q.push_back(model(e0 + 8 * S + j * (8 * S + 1), REF, 0, 0, 0));
    bus.start = 1'b1;
    repeat (2 * (8 * S + 1) + 2) tick();
    bus.start = 1'b0;
    repeat (8 * S + 2) tick();
    chk("b2b_drained", q.size(), 0);

    // Asynchronous reset at row 5, then a full sweep from row 0.
    tt = 8'h0F;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5 * S + 1) tick();
    chk("pre_reset_row", bus.gate_in, 5);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {bus.gate_in, bus.busy, bus.done, bus.table_out, bus.pass,
                           bus.mismatch, bus.unstable}, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    run_sweep(REF, 0, 0, 0, 0);

    // Random gate functions with an optional single glitch.
    for (int i = 0; i < 12; i++) begin
      run_sweep(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                $urandom_range(0, 2), 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (4) tick();
    chk("pending_done", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
